i2s_tx_feeder: RTL and testbench
================================

// Module: i2s_tx_feeder
// PURPOSE
//  Upstream stage of the I2S transmitter. It runs on the system clock and generates SCLK and LRCK
//  by counter division. It buffers stereo samples from a valid/ready source in a small FIFO.
//  It presents pldata/prdata words that are held stable across each channel's load instant.
//  Its outputs drive the transmitter's sclk_in, lrck_in, pldata_in and prdata_in directly.
// PARAMETERS
//  PDATA_WIDTH  32  bits per channel word; one LRCK half-frame = PDATA_WIDTH SCLK periods
//  SCLK_DIV     4   clk_in cycles per SCLK half-period (>=1); SCLK period = 2*SCLK_DIV clk
//  FIFO_DEPTH   4   stereo entries in the FIFO (power of 2, >=2)
// PORTS
//  clk_in        in   1                  system clock; every register is clocked on its rising edge
//  rst_n_in      in   1                  asynchronous, active-low reset
//  enable_in     in   1                  1 = generate clocks and consume samples
//  s_valid_in    in   1                  source sample valid
//  s_ready_out   out  1                  FIFO can accept (= !full)
//  s_ldata_in    in   PDATA_WIDTH        left sample
//  s_rdata_in    in   PDATA_WIDTH        right sample
//  sclk_out      out  1                  bit clock
//  lrck_out      out  1                  word select; 0 = left, 1 = right
//  pldata_out    out  PDATA_WIDTH        left word to the transmitter
//  prdata_out    out  PDATA_WIDTH        right word to the transmitter
//  fifo_level_out out $clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  underrun_out  out  1                  one-clk pulse: pop attempted while FIFO empty
// BEHAVIOUR
//  - Reset values: sclk=0, lrck=0, pldata=0, prdata=0, staged right word=0, level=0,
//    underrun=0, all counters 0. s_ready_out=1 during reset because it is derived from the empty FIFO.
//  - Divider: div_cnt counts 0..SCLK_DIV-1. At terminal count, sclk_out toggles and div_cnt wraps to 0.
//  - Bit counter: bit_cnt counts 0..PDATA_WIDTH-1 and advances on each SCLK 1->0 toggle.
//    On wrap, lrck_out toggles in the same clk as that SCLK fall. LRCK therefore changes only on SCLK falling edges.
//  - Pop event: the clk in which lrck_out toggles 0->1.
//    - Pop one entry. pldata_out <= entry.l. Stage entry.r in rstage.
//    - Each word changes at least a half-frame before the transmitter loads it.
//  - On the lrck_out toggle 1->0: prdata_out <= rstage.
//  - FIFO push: a sample is accepted when s_valid_in && s_ready_out.
//    - full and s_ready_out derive from registered occupancy.
//    - Push and pop in the same clk: level is unchanged, both succeed.
//    - When full, a same-clk pop does not re-open ready until the next clk.
//    - When empty, a same-clk push does not bypass to the pop. The pop underruns and the pushed entry is kept.
//  - Underrun: the pop finds the FIFO empty.
//    - underrun_out=1 for exactly that clk.
//    - Output words and rstage per CONFIGURATION.
//    - No FIFO pointer change.
//  - Pointers: wrap modulo FIFO_DEPTH. level ranges 0..FIFO_DEPTH.
//  - enable_in=0, taking effect the next clk, and also mid-frame:
//    - div_cnt, bit_cnt, sclk_out and lrck_out are forced to 0. No pops occur.
//    - FIFO contents, pldata_out, prdata_out and rstage are retained. Pushes are still accepted.
//  - enable_in 0->1: the first SCLK rise occurs SCLK_DIV clks later. The frame starts on the left channel.
//  - Asynchronous reset mid-frame clears everything immediately; FIFO contents are discarded.
// CONFIGURATION
//  I2S_FEEDER_HOLD_EN
//  - Defined: on underrun, pldata_out and rstage keep their previous values, so the last sample repeats.
//  - Undefined: on underrun, pldata_out and rstage are loaded with 0, so silence is output.
// STRUCTURE
//  - i2s_pkg.vh holds the shared constants. This block and the transmitter both include it.
//    - I2S_LEFT=1'b0 and I2S_RIGHT=1'b1 for the lrck encoding.
//    - Default PDATA_WIDTH.
//    - clog2 function.
//  - Sub-module i2s_sample_fifo: a synchronous FIFO with width 2*PDATA_WIDTH.
//    - Ports push, pop, full, empty and level.
//    - The top level contains only the divider, the counters, the output registers and the underrun logic.
// TESTING
//  1. Frame timing, SCLK_DIV=4, W=32, enable=1: SCLK period is 8 clk. LRCK toggles every 256 clk,
//     only in a clk where sclk_out falls.
//  2. Data path, push {L=32'hA5A5_0001, R=32'h5A5A_0002} before enable:
//     - At the first lrck 0->1, pldata_out=A5A5_0001.
//     - At the next lrck 1->0, prdata_out=5A5A_0002.
//     - A transmitter model serialises both words MSB first.
//  3. Backpressure: hold s_valid_in=1 with sclk stopped. Four pushes are accepted, then s_ready_out=0
//     and level=4. After a pop, ready returns the next clk.
//  4. Underrun with the FIFO empty at a pop:
//     - underrun_out is high for one clk.
//     - pldata_out=0 with the macro undefined; the previous value is held with I2S_FEEDER_HOLD_EN.
//  5. Simultaneous events: with level=1, push in the pop clk, so level stays 1 and underrun=0.
//     With level=0, push in the pop clk, so underrun=1 and level becomes 1.
//  6. enable_in dropped mid-word (bit_cnt=17): the next clk has sclk=lrck=0 and counters at 0, level unchanged.
//     After re-enable, the first SCLK rise comes 4 clk later with lrck=0.

Source files
------------

// File: rtl/i2s_pkg.sv
// i2s_pkg: constants shared by the I2S feeder and transmitter (lrck encoding, default width, clog2).
package i2s_pkg;
    localparam logic I2S_LEFT = 1'b0;
    localparam logic I2S_RIGHT = 1'b1;
    localparam int PDATA_WIDTH_DEF = 32;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/i2s_sample_fifo.sv
// i2s_sample_fifo: synchronous FIFO of stereo entries; full/empty come from registered occupancy.
module i2s_sample_fifo
    import i2s_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  level
);
    localparam int AW = clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic push_ok, pop_ok;
    assign full = level == (AW+1)'(DEPTH);
    assign empty = level == '0;
    assign push_ok = push && !full;
    assign pop_ok = pop && !empty;
    assign dout = mem[rptr];
    always_ff @(posedge clk_in)
        if (push_ok) mem[wptr] <= din;
    always_ff @(posedge clk_in or negedge rst_n_in)
        if (!rst_n_in) begin
            wptr <= '0;
            rptr <= '0;
            level <= '0;
        end else begin
            wptr <= push_ok ? wptr + 1'b1 : wptr;
            rptr <= pop_ok ? rptr + 1'b1 : rptr;
            level <= push_ok && !pop_ok ? level + 1'b1 : pop_ok && !push_ok ? level - 1'b1 : level;
        end
endmodule

// File: rtl/i2s_tx_feeder.sv
// i2s_tx_feeder: divides clk into SCLK/LRCK, pops stereo samples from a FIFO and holds pldata/prdata for the transmitter.
// I2S_FEEDER_HOLD_EN: when defined, an underrun repeats the last sample instead of outputting silence.
module i2s_tx_feeder
    import i2s_pkg::*;
#(
    parameter int PDATA_WIDTH = PDATA_WIDTH_DEF,
    parameter int SCLK_DIV = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         enable_in,
    input  logic                         s_valid_in,
    output logic                         s_ready_out,
    input  logic [PDATA_WIDTH-1:0]       s_ldata_in,
    input  logic [PDATA_WIDTH-1:0]       s_rdata_in,
    output logic                         sclk_out,
    output logic                         lrck_out,
    output logic [PDATA_WIDTH-1:0]       pldata_out,
    output logic [PDATA_WIDTH-1:0]       prdata_out,
    output logic [clog2(FIFO_DEPTH):0]   fifo_level_out,
    output logic                         underrun_out
);
    localparam int DW = SCLK_DIV > 1 ? clog2(SCLK_DIV) : 1;
    localparam int BW = clog2(PDATA_WIDTH);
    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic [PDATA_WIDTH-1:0] rstage;
    logic [2*PDATA_WIDTH-1:0] entry;
    logic full, empty, tc, fall, wrap, pop, rsel;
    assign tc = enable_in && div_cnt == DW'(SCLK_DIV-1);
    assign fall = tc && sclk_out;
    assign wrap = fall && bit_cnt == BW'(PDATA_WIDTH-1);
    assign pop = wrap && lrck_out == I2S_LEFT;
    assign rsel = wrap && lrck_out == I2S_RIGHT;
    assign s_ready_out = !full;
    i2s_sample_fifo #(.WIDTH(2*PDATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .push(s_valid_in),
        .din({s_ldata_in, s_rdata_in}),
        .pop(pop),
        .dout(entry),
        .full(full),
        .empty(empty),
        .level(fifo_level_out)
    );
    // Left word and staged right word are loaded at the 0->1 LRCK toggle, a half-frame before use.
    always_ff @(posedge clk_in or negedge rst_n_in)
        if (!rst_n_in) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            sclk_out <= 1'b0;
            lrck_out <= I2S_LEFT;
            pldata_out <= '0;
            prdata_out <= '0;
            rstage <= '0;
            underrun_out <= 1'b0;
        end else begin
            div_cnt <= !enable_in || tc ? '0 : div_cnt + 1'b1;
            sclk_out <= enable_in && (tc ? ~sclk_out : sclk_out);
            bit_cnt <= !enable_in || wrap ? '0 : fall ? bit_cnt + 1'b1 : bit_cnt;
            lrck_out <= enable_in && (wrap ? ~lrck_out : lrck_out);
            underrun_out <= pop && empty;
`ifdef I2S_FEEDER_HOLD_EN
            if (pop && !empty) begin
                pldata_out <= entry[2*PDATA_WIDTH-1:PDATA_WIDTH];
                rstage <= entry[PDATA_WIDTH-1:0];
            end
`else
            if (pop) begin
                pldata_out <= empty ? '0 : entry[2*PDATA_WIDTH-1:PDATA_WIDTH];
                rstage <= empty ? '0 : entry[PDATA_WIDTH-1:0];
            end
`endif
            if (rsel) prdata_out <= rstage;
        end
endmodule

// File: tb/tb_i2s_tx_feeder.sv
// tb_i2s_tx_feeder: directed checks of frame timing, data path, backpressure, underrun and enable handling.
module tb_i2s_tx_feeder;
    localparam int W = 32;
    logic clk_in = 1'b0, rst_n_in = 1'b0, enable_in = 1'b0, s_valid_in = 1'b0;
    logic [W-1:0] s_ldata_in = '0, s_rdata_in = '0;
    logic s_ready_out, sclk_out, lrck_out, underrun_out;
    logic [W-1:0] pldata_out, prdata_out;
    logic [2:0] fifo_level_out;
    int n_chk = 0, n_fail = 0;
    i2s_tx_feeder #(.PDATA_WIDTH(W), .SCLK_DIV(4), .FIFO_DEPTH(4)) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .enable_in(enable_in),
        .s_valid_in(s_valid_in),
        .s_ready_out(s_ready_out),
        .s_ldata_in(s_ldata_in),
        .s_rdata_in(s_rdata_in),
        .sclk_out(sclk_out),
        .lrck_out(lrck_out),
        .pldata_out(pldata_out),
        .prdata_out(prdata_out),
        .fifo_level_out(fifo_level_out),
        .underrun_out(underrun_out)
    );
    always #5 clk_in = ~clk_in;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic step(input int k);
        repeat (k) @(negedge clk_in);
    endtask
    task automatic push(input logic [63:0] e);
        s_ldata_in = e[63:32];
        s_rdata_in = e[31:0];
        s_valid_in = 1'b1;
    endtask
    task automatic wait_lrck(input logic v, output int c, output logic fell);
        logic prev;
        c = 0;
        prev = sclk_out;
        while (lrck_out !== v && c < 600) begin
            prev = sclk_out;
            @(negedge clk_in);
            c++;
        end
        fell = prev && !sclk_out;
    endtask
    initial begin
        logic [63:0] e [8];
        logic [31:0] held, exp_ur;
        int c;
        logic f;
        e[0] = 64'hA5A5_0001_5A5A_0002;
        for (int i = 1; i < 8; i++) e[i] = {32'h1111_0000 + 32'(i), 32'h2222_0000 + 32'(i)};
`ifdef I2S_FEEDER_HOLD_EN
        exp_ur = e[5][63:32];
`else
        exp_ur = '0;
`endif
        step(2);
        chk("rst_sclk", sclk_out, 0);
        chk("rst_lrck", lrck_out, 0);
        chk("rst_pldata", pldata_out, 0);
        chk("rst_prdata", prdata_out, 0);
        chk("rst_level", fifo_level_out, 0);
        chk("rst_ready", s_ready_out, 1);
        chk("rst_underrun", underrun_out, 0);
        rst_n_in = 1'b1;
        step(1);
        for (int i = 0; i < 5; i++) begin
            push(e[i]);
            step(1);
            if (i == 0) chk("first_push_level", fifo_level_out, 1);
        end
        s_valid_in = 1'b0;
        chk("full_level", fifo_level_out, 4);
        chk("full_ready", s_ready_out, 0);
        step(2);
        chk("disabled_sclk", sclk_out, 0);
        enable_in = 1'b1;
        wait_lrck(1'b1, c, f);
        chk("pop1_time", c, 256);
        chk("pop1_on_sclk_fall", f, 1);
        chk("pop1_pldata", pldata_out, 64'hA5A5_0001);
        chk("pop1_level", fifo_level_out, 3);
        chk("pop1_ready", s_ready_out, 1);
        held = pldata_out;
        wait_lrck(1'b0, c, f);
        chk("fall1_time", c, 256);
        chk("fall1_on_sclk_fall", f, 1);
        chk("fall1_prdata", prdata_out, 64'h5A5A_0002);
        chk("pldata_stable", pldata_out, held);
        wait_lrck(1'b1, c, f);
        chk("pop2_pldata", pldata_out, e[1][63:32]);
        chk("pop2_level", fifo_level_out, 2);
        wait_lrck(1'b0, c, f);
        chk("fall2_prdata", prdata_out, e[1][31:0]);
        wait_lrck(1'b1, c, f);
        chk("pop3_pldata", pldata_out, e[2][63:32]);
        chk("pop3_level", fifo_level_out, 1);
        wait_lrck(1'b0, c, f);
        chk("fall3_prdata", prdata_out, e[2][31:0]);
        step(255);
        push(e[5]);
        step(1);
        s_valid_in = 1'b0;
        chk("pop4_lrck", lrck_out, 1);
        chk("pop4_level", fifo_level_out, 1);
        chk("pop4_underrun", underrun_out, 0);
        chk("pop4_pldata", pldata_out, e[3][63:32]);
        wait_lrck(1'b0, c, f);
        chk("fall4_prdata", prdata_out, e[3][31:0]);
        wait_lrck(1'b1, c, f);
        chk("pop5_pldata", pldata_out, e[5][63:32]);
        chk("pop5_level", fifo_level_out, 0);
        chk("pop5_underrun", underrun_out, 0);
        wait_lrck(1'b0, c, f);
        chk("fall5_prdata", prdata_out, e[5][31:0]);
        step(255);
        push(e[6]);
        step(1);
        s_valid_in = 1'b0;
        chk("pop6_lrck", lrck_out, 1);
        chk("pop6_underrun", underrun_out, 1);
        chk("pop6_level", fifo_level_out, 1);
        chk("pop6_pldata", pldata_out, exp_ur);
        step(1);
        chk("underrun_one_clk", underrun_out, 0);
        step(139);
        chk("mid_word_sclk", sclk_out, 1);
        chk("mid_word_lrck", lrck_out, 1);
        enable_in = 1'b0;
        step(1);
        chk("dis_sclk", sclk_out, 0);
        chk("dis_lrck", lrck_out, 0);
        chk("dis_level", fifo_level_out, 1);
        chk("dis_pldata", pldata_out, exp_ur);
        chk("dis_prdata", prdata_out, e[5][31:0]);
        push(e[7]);
        step(1);
        s_valid_in = 1'b0;
        chk("dis_push_level", fifo_level_out, 2);
        step(3);
        enable_in = 1'b1;
        step(3);
        chk("reen_sclk_low", sclk_out, 0);
        step(1);
        chk("reen_sclk_rise", sclk_out, 1);
        chk("reen_lrck", lrck_out, 0);
        wait_lrck(1'b1, c, f);
        chk("pop7_time", c, 252);
        chk("pop7_pldata", pldata_out, e[6][63:32]);
        chk("pop7_level", fifo_level_out, 1);
        wait_lrck(1'b0, c, f);
        chk("fall7_prdata", prdata_out, e[6][31:0]);
        step(3);
        #2 rst_n_in = 1'b0;
        #1;
        chk("async_level", fifo_level_out, 0);
        chk("async_pldata", pldata_out, 0);
        chk("async_prdata", prdata_out, 0);
        chk("async_sclk", sclk_out, 0);
        chk("async_ready", s_ready_out, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
